// File: rtl/n64adv_igr_decoder.sv
// n64adv_igr_decoder
// In-game-routine command decoder fed by the controller sniffer (CLK_4M domain).
// Watches completed controller packets for three button combos held over
// HOLD_PKTS consecutive packets and emits one-cycle command pulses.
// Optional feature macro: IGR_STICK_CHECK_EN (joystick must be centred for a
// packet to count as a combo match; STICK_THR sets the dead zone).
module n64adv_igr_decoder #(
  parameter logic [3:0]  HOLD_PKTS   = 4'd4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd40000,
  parameter logic [7:0]  STICK_THR   = 8'd16
) (
  input  logic        CLK_4M,
  input  logic        RST,
  input  logic [31:0] ctrl_data,
  input  logic        ctrl_valid,
  input  logic        use_igr,
  output logic        igr_reset,
  output logic        igr_deblur_tgl,
  output logic        igr_15bit_tgl,
  output logic        igr_busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  // Bits 9:8 (joystick-reset flag and the always-zero bit) never take part.
  localparam logic [15:0] BTN_MASK     = 16'hFCFF;
  localparam logic [15:0] COMBO_RESET  = 16'h0C0F;
  localparam logic [15:0] COMBO_DEBLUR = 16'h880C;
  localparam logic [15:0] COMBO_MODE15 = 16'h480C;

  localparam logic [1:0] CMD_NONE   = 2'd0;
  localparam logic [1:0] CMD_RESET  = 2'd1;
  localparam logic [1:0] CMD_DEBLUR = 2'd2;
  localparam logic [1:0] CMD_MODE15 = 2'd3;

  function automatic logic [1:0] combo_code(input logic [15:0] btn);
    logic [15:0] masked;
    masked = btn & BTN_MASK;
    case (masked)
      COMBO_RESET:  combo_code = CMD_RESET;
      COMBO_DEBLUR: combo_code = CMD_DEBLUR;
      COMBO_MODE15: combo_code = CMD_MODE15;
      default:      combo_code = CMD_NONE;
    endcase
  endfunction

  logic stick_ok;

`ifdef IGR_STICK_CHECK_EN
  // Magnitude is taken at 9 bits so that -128 does not wrap back to -128.
  function automatic logic stick_centred(input logic [7:0] raw);
    logic signed [8:0] val;
    logic [8:0]        mag;
    val = $signed({raw[7], raw});
    mag = val[8] ? $unsigned(-val) : $unsigned(val);
    stick_centred = (mag < {1'b0, STICK_THR});
  endfunction

  assign stick_ok = stick_centred(ctrl_data[23:16]) && stick_centred(ctrl_data[31:24]);
`else
  // Stick bytes and threshold have no effect in this build.
  logic unused_stick;
  assign stick_ok     = 1'b1;
  assign unused_stick = ^{ctrl_data[31:16], STICK_THR};
`endif

  logic [1:0] pkt_code;
  assign pkt_code = stick_ok ? combo_code(ctrl_data[15:0]) : CMD_NONE;

  state_t      state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [1:0]  fire_cmd;
  logic        igr_reset_q, igr_reset_d;
  logic        igr_deblur_tgl_q, igr_deblur_tgl_d;
  logic        igr_15bit_tgl_q, igr_15bit_tgl_d;
  logic        igr_busy_q;

  // Next-state logic: enable override, packet handling, then idle timeout.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    hold_cnt_d = hold_cnt_q;
    to_cnt_d   = to_cnt_q;
    fire_cmd   = CMD_NONE;

    if (!use_igr) begin
      state_d    = ST_IDLE;
      cmd_d      = CMD_NONE;
      hold_cnt_d = 4'd0;
      to_cnt_d   = 16'd0;
    end else if (ctrl_valid) begin
      to_cnt_d = 16'd0;
      case (state_q)
        ST_IDLE: begin
          if (pkt_code != CMD_NONE) begin
            cmd_d      = pkt_code;
            hold_cnt_d = 4'd1;
            if (HOLD_PKTS <= 4'd1) begin
              fire_cmd = pkt_code;
              state_d  = ST_WAIT_REL;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (pkt_code == CMD_NONE) begin
            state_d    = ST_IDLE;
            cmd_d      = CMD_NONE;
            hold_cnt_d = 4'd0;
          end else if (pkt_code == cmd_q) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
            if (hold_cnt_d >= HOLD_PKTS) begin
              fire_cmd = cmd_q;
              state_d  = ST_WAIT_REL;
            end
          end else begin
            // A different combo restarts the count on the new command.
            cmd_d      = pkt_code;
            hold_cnt_d = 4'd1;
          end
        end
        ST_WAIT_REL: begin
          if (pkt_code == CMD_NONE) begin
            state_d    = ST_IDLE;
            cmd_d      = CMD_NONE;
            hold_cnt_d = 4'd0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          cmd_d      = CMD_NONE;
          hold_cnt_d = 4'd0;
        end
      endcase
    end else begin
      if (to_cnt_q != TIMEOUT_CYC) begin
        to_cnt_d = to_cnt_q + 16'd1;
      end
      // Abandon on the cycle the counter reaches saturation.
      if ((to_cnt_d == TIMEOUT_CYC) && (state_q != ST_IDLE)) begin
        state_d    = ST_IDLE;
        cmd_d      = CMD_NONE;
        hold_cnt_d = 4'd0;
      end
    end

    igr_reset_d      = (fire_cmd == CMD_RESET);
    igr_deblur_tgl_d = (fire_cmd == CMD_DEBLUR);
    igr_15bit_tgl_d  = (fire_cmd == CMD_MODE15);
  end

  // FSM state, counters and registered outputs; reset clears pulses in flight.
  always_ff @(posedge CLK_4M or posedge RST) begin
    if (RST) begin
      state_q          <= ST_IDLE;
      cmd_q            <= CMD_NONE;
      hold_cnt_q       <= 4'd0;
      to_cnt_q         <= 16'd0;
      igr_reset_q      <= 1'b0;
      igr_deblur_tgl_q <= 1'b0;
      igr_15bit_tgl_q  <= 1'b0;
      igr_busy_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cmd_q            <= cmd_d;
      hold_cnt_q       <= hold_cnt_d;
      to_cnt_q         <= to_cnt_d;
      igr_reset_q      <= igr_reset_d;
      igr_deblur_tgl_q <= igr_deblur_tgl_d;
      igr_15bit_tgl_q  <= igr_15bit_tgl_d;
      igr_busy_q       <= (state_q != ST_IDLE);
    end
  end

  assign igr_reset      = igr_reset_q;
  assign igr_deblur_tgl = igr_deblur_tgl_q;
  assign igr_15bit_tgl  = igr_15bit_tgl_q;
  assign igr_busy       = igr_busy_q;

endmodule

// File: tb/tb_n64adv_igr_decoder.sv
// Testbench for n64adv_igr_decoder: directed vector table, hand-written
// enable/reset/timeout sequences and randomized packets against a
// streak-counting reference model.
module tb_n64adv_igr_decoder;

  localparam int HOLD = 4;
  localparam int TO   = 40000;
  localparam int THR  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl_data;
  logic        ctrl_valid;
  logic        use_igr;
  logic        igr_reset, igr_deblur_tgl, igr_15bit_tgl, igr_busy;

  always #5 clk = ~clk;

  n64adv_igr_decoder #(
    .HOLD_PKTS  (4'd4),
    .TIMEOUT_CYC(16'd40000),
    .STICK_THR  (8'd16)
  ) dut (
    .CLK_4M        (clk),
    .RST           (rst),
    .ctrl_data     (ctrl_data),
    .ctrl_valid    (ctrl_valid),
    .use_igr       (use_igr),
    .igr_reset     (igr_reset),
    .igr_deblur_tgl(igr_deblur_tgl),
    .igr_15bit_tgl (igr_15bit_tgl),
    .igr_busy      (igr_busy)
  );

  int     n_total = 0;
  int     n_pass  = 0;
  longint cyc     = 0;

  // Reference model state: a packet streak only counts while armed; firing
  // disarms until a non-combo packet (or timeout / reset / disable) re-arms.
  bit     m_armed = 1'b1;
  int     m_code  = 0;
  int     m_len   = 0;
  longint m_last  = 0;

  logic [15:0] combos [3] = '{16'h0C0F, 16'h880C, 16'h480C};

  typedef struct {
    logic [31:0] data;
    int          gap;
    logic [2:0]  exp;
  } vec_t;
  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int classify(input logic [31:0] d);
    logic [15:0] b;
`ifdef IGR_STICK_CHECK_EN
    int x, y;
    x = int'($signed(d[23:16]));
    y = int'($signed(d[31:24]));
    if (x < 0) x = -x;
    if (y < 0) y = -y;
    if (x >= THR || y >= THR) return 0;
`endif
    b = d[15:0] & 16'hFCFF;
    if (b == 16'h0C0F) return 1;
    if (b == 16'h880C) return 2;
    if (b == 16'h480C) return 3;
    return 0;
  endfunction

  task automatic model_clear();
    m_armed = 1'b1;
    m_len   = 0;
    m_last  = cyc;
  endtask

  task automatic model_pkt(input logic [31:0] d, input longint e, output logic [2:0] exp);
    int code;
    exp = 3'b000;
    if (e - m_last - 1 >= TO) begin
      m_armed = 1'b1;
      m_len   = 0;
    end
    m_last = e;
    code = classify(d);
    if (code == 0) begin
      m_armed = 1'b1;
      m_len   = 0;
    end else if (m_armed) begin
      if (m_len > 0 && code == m_code) m_len++;
      else begin
        m_code = code;
        m_len  = 1;
      end
      if (m_len >= HOLD) begin
        case (code)
          1:       exp = 3'b100;
          2:       exp = 3'b010;
          default: exp = 3'b001;
        endcase
        m_armed = 1'b0;
        m_len   = 0;
      end
    end
  endtask

  function automatic logic model_busy();
    return !m_armed || (m_len != 0);
  endfunction

  // gap idle cycles, then one valid cycle; got is sampled in the following cycle
  task automatic send(input logic [31:0] d, input int gap, output logic [2:0] got, output logic stray);
    stray = 1'b0;
    for (int i = 0; i < gap; i++) begin
      step();
      if ({igr_reset, igr_deblur_tgl, igr_15bit_tgl} != 3'b000) stray = 1'b1;
    end
    ctrl_data  = d;
    ctrl_valid = 1'b1;
    step();
    ctrl_valid = 1'b0;
    got = {igr_reset, igr_deblur_tgl, igr_15bit_tgl};
  endtask

  task automatic pkt(input string name, input logic [31:0] d, input int gap,
                     input logic [2:0] fixed_exp, input bit use_model);
    logic [2:0] got, mexp;
    logic       stray;
    send(d, gap, got, stray);
    model_pkt(d, cyc, mexp);
    chk({name, "_pulse"}, 32'(got), 32'(use_model ? mexp : fixed_exp));
    chk({name, "_stray"}, 32'(stray), 32'd0);
  endtask

  task automatic add(input logic [31:0] d, input int gap, input logic [2:0] exp, input int n);
    vec_t v;
    v.data = d;
    v.gap  = gap;
    v.exp  = 3'b000;
    for (int i = 0; i < n - 1; i++) tbl.push_back(v);
    v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  got;
    logic        stray;
    logic [31:0] d;
    int          fav, r, gap;

    // Directed vector table (state carries from row to row).
    add(32'h00000C0F, 200, 3'b100, 4);
    add(32'h00000C0F, 200, 3'b000, 1);
    add(32'h00000000, 200, 3'b000, 1);
    add(32'h0000880C, 20, 3'b000, 3);
    add(32'h00000000, 20, 3'b000, 1);
    add(32'h0000880C, 20, 3'b010, 4);
    add(32'h00000000, 20, 3'b000, 1);
    add(32'h0000880C, 20, 3'b000, 2);
    add(32'h0000480C, 20, 3'b001, 4);
    add(32'h00000000, 20, 3'b000, 1);
    add(32'h00000F0F, 20, 3'b100, 4);
    add(32'h00000000, 20, 3'b000, 1);
    add(32'h00000C1F, 20, 3'b000, 4);
    add(32'h00000000, 20, 3'b000, 1);
`ifdef IGR_STICK_CHECK_EN
    add(32'h14000C0F, 20, 3'b000, 4);
`else
    add(32'h14000C0F, 20, 3'b100, 4);
`endif
    add(32'h00000000, 20, 3'b000, 1);
    add(32'h08000C0F, 20, 3'b100, 4);
    add(32'h00000000, 20, 3'b000, 1);
    add(32'h0000480C, 0, 3'b001, 4);
    add(32'h0000480C, 0, 3'b000, 1);
    add(32'h00000C0F, 0, 3'b000, 4);
    add(32'h00000000, 0, 3'b000, 1);
    add(32'h00000C0F, 3, 3'b000, 2);
    add(32'h0000880C, 3, 3'b000, 2);
    add(32'h00000C0F, 3, 3'b100, 4);
    add(32'h00000000, 3, 3'b000, 1);

    rst        = 1'b1;
    use_igr    = 1'b1;
    ctrl_valid = 1'b0;
    ctrl_data  = 32'd0;
    repeat (3) step();
    chk("rst_reset", 32'(igr_reset), 32'd0);
    chk("rst_deblur", 32'(igr_deblur_tgl), 32'd0);
    chk("rst_15bit", 32'(igr_15bit_tgl), 32'd0);
    chk("rst_busy", 32'(igr_busy), 32'd0);
    rst = 1'b0;
    step();
    model_clear();

    for (int i = 0; i < tbl.size(); i++)
      pkt($sformatf("tbl%0d", i), tbl[i].data, tbl[i].gap, tbl[i].exp, 1'b0);

    // Timeout: two combo packets, then a full timeout of silence.
    pkt("to_a", 32'h00000C0F, 20, 3'b000, 1'b0);
    pkt("to_b", 32'h00000C0F, 20, 3'b000, 1'b0);
    for (int i = 0; i < TO; i++) step();
    chk("busy_at_timeout", 32'(igr_busy), 32'd1);
    step();
    chk("busy_after_timeout", 32'(igr_busy), 32'd0);
    pkt("to_c", 32'h00000C0F, 20, 3'b000, 1'b0);
    pkt("to_d", 32'h00000C0F, 20, 3'b000, 1'b0);
    pkt("to_clr", 32'h00000000, 20, 3'b000, 1'b0);

    // Disabled decoder ignores everything.
    use_igr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(32'h00000C0F, 5, got, stray);
      chk($sformatf("dis%0d_pulse", i), 32'(got), 32'd0);
      chk($sformatf("dis%0d_stray", i), 32'(stray), 32'd0);
    end
    step();
    chk("dis_busy", 32'(igr_busy), 32'd0);
    use_igr = 1'b1;
    model_clear();

    // Disable mid-hold drops the count.
    for (int i = 0; i < 3; i++) pkt($sformatf("en_h%0d", i), 32'h00000C0F, 5, 3'b000, 1'b0);
    use_igr = 1'b0;
    step();
    step();
    use_igr = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) pkt($sformatf("en_r%0d", i), 32'h00000C0F, 5, 3'b000, 1'b0);
    pkt("en_r3", 32'h00000C0F, 5, 3'b100, 1'b0);
    pkt("en_clr", 32'h00000000, 5, 3'b000, 1'b0);

    // Asynchronous reset mid-hold, then a pulse cleared in flight.
    pkt("rh_a", 32'h00000C0F, 5, 3'b000, 1'b0);
    pkt("rh_b", 32'h00000C0F, 5, 3'b000, 1'b0);
    step();
    chk("rh_busy_before", 32'(igr_busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rh_busy_async", 32'(igr_busy), 32'd0);
    step();
    rst = 1'b0;
    step();
    model_clear();
    for (int i = 0; i < 3; i++) pkt($sformatf("rh_n%0d", i), 32'h00000C0F, 5, 3'b000, 1'b0);
    pkt("rh_n3", 32'h00000C0F, 5, 3'b100, 1'b0);
    #2 rst = 1'b1;
    #1 chk("pulse_async_clear", 32'(igr_reset), 32'd0);
    step();
    rst = 1'b0;
    step();
    model_clear();

    // Randomized packets against the reference model.
    fav = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) fav = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      d = 32'd0;
      if (r <= 5)      d[15:0] = combos[fav];
      else if (r == 6) d[15:0] = 16'h0000;
      else if (r == 7) d[15:0] = 16'($urandom);
      else if (r == 8) d[15:0] = combos[fav] | (16'd1 << $urandom_range(0, 15));
      else             d[15:0] = combos[$urandom_range(0, 2)];
      if ($urandom_range(0, 3) == 0) d[9:8] = 2'($urandom);
`ifdef IGR_STICK_CHECK_EN
      if ($urandom_range(0, 3) == 0) d[31:16] = 16'($urandom);
      else begin
        d[23:16] = 8'($urandom_range(0, 30)) - 8'd15;
        d[31:24] = 8'($urandom_range(0, 30)) - 8'd15;
      end
`else
      d[31:16] = 16'($urandom);
`endif
      gap = int'($urandom_range(0, 30));
      if (gap >= 3) begin
        step();
        step();
        chk($sformatf("rnd%0d_busy", n), 32'(igr_busy), 32'(model_busy()));
        gap = gap - 2;
      end
      pkt($sformatf("rnd%0d", n), d, gap, 3'b000, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/n64adv_igr_decoder.md
# n64adv_igr_decoder

In-game-routine (IGR) command decoder directly downstream of the controller sniffer. Consumes each completed 32-bit controller packet plus its one-cycle valid strobe in the CLK_4M domain. Recognises three fixed button combos held over consecutive packets. Emits one-cycle command pulses: console reset request, VI-deblur toggle, 15-bit-mode toggle.

## Interface
- HOLD_PKTS, 4, consecutive matching packets required before a command fires; legal range 1..15.
- TIMEOUT_CYC, 40000, CLK_4M cycles without a packet before the hold state is abandoned (10 ms); 16-bit.
- STICK_THR, 16, joystick dead-zone magnitude used only when IGR_STICK_CHECK_EN is defined; 8-bit.
- CLK_4M  input  1  sole clock.
- RST  input  1  asynchronous, active-high reset.
- ctrl_data  input  32  packet; [7:0] A,B,Z,St,Du,Dd,Dl,Dr; [15:8] JoyRst,0,L,R,Cu,Cd,Cl,Cr; [23:16] X; [31:24] Y (two's complement).
- ctrl_valid  input  1  one-cycle strobe; ctrl_data is stable in that cycle.
- use_igr  input  1  level enable, quasi-static.
- igr_reset  output  1  one-cycle pulse: reset requested.
- igr_deblur_tgl  output  1  one-cycle pulse: toggle VI-deblur.
- igr_15bit_tgl  output  1  one-cycle pulse: toggle 15-bit mode.
- igr_busy  output  1  high while state is not IDLE.

## Operation
- Match: compare ctrl_data[15:0] with bits 9:8 masked to zero.
  - RESET = 16'h0C0F (A+B+Z+St+L+R).
  - DEBLUR = 16'h880C (Z+St+R+Cr).
  - MODE15 = 16'h480C (Z+St+R+Cl).
  - Exact equality only; no other button may be set.
  - The three combos are mutually exclusive.
- Registers: cmd[1:0] (0 none, 1 reset, 2 deblur, 3 mode15); hold_cnt[3:0]; to_cnt[15:0].
- FSM, evaluated only on ctrl_valid unless noted:
  - IDLE: a packet matching a combo loads cmd, sets hold_cnt=1 and goes to HOLD. If HOLD_PKTS==1, it fires immediately and goes to WAIT_REL.
  - HOLD:
    - A packet matching the same combo increments hold_cnt.
    - When hold_cnt reaches HOLD_PKTS, the matching pulse fires and the FSM goes to WAIT_REL.
    - A packet matching a different combo reloads cmd with hold_cnt=1 and stays in HOLD.
    - A non-matching packet goes to IDLE with cmd=0.
  - WAIT_REL: stays until a packet matching no combo arrives, then goes to IDLE. Holding buttons never refires.
- Timeout: to_cnt clears on every ctrl_valid and otherwise increments, saturating at TIMEOUT_CYC. At saturation in HOLD or WAIT_REL, go to IDLE.
- use_igr low: FSM forced to IDLE, counters cleared, no pulses. This has priority over everything except RST.

## Timing
- Reset values: all outputs 0; state IDLE; cmd 0; hold_cnt 0; to_cnt 0.
- Pulse latency: the pulse is registered high in the cycle after the qualifying ctrl_valid and lasts exactly one cycle. At most one pulse output is high in any cycle.
- igr_busy is registered and follows state with one cycle of latency.
- Simultaneous events:
  - ctrl_valid in the same cycle as timeout saturation: ctrl_valid wins, the packet is processed and to_cnt clears.
  - ctrl_valid with use_igr low: ignored.
- RST mid-HOLD: any pending count is lost. A pulse in flight is cleared asynchronously.
- Back-to-back ctrl_valid on consecutive cycles must be handled. The sniffer normally spaces packets by at least 100 cycles.

## Configuration
- IGR_STICK_CHECK_EN defined:
  - A packet counts as matching only if both signed X and Y satisfy |value| < STICK_THR.
  - An off-centre packet is treated as non-matching.
- IGR_STICK_CHECK_EN undefined: bits [31:16] are ignored entirely and STICK_THR is unused.

## Test plan
- use_igr=1, 4 packets of 32'h00000C0F spaced 200 cycles -> igr_reset high for exactly 1 cycle, starting the cycle after the 4th ctrl_valid; a 5th identical packet produces no pulse.
- 3 packets of 16'h880C, then 16'h0000, then 4 packets of 16'h880C -> no pulse after the first 3; igr_deblur_tgl fires once after the 4th packet of the second run.
- 2 packets of 16'h880C, then 4 packets of 16'h480C -> only igr_15bit_tgl fires; igr_deblur_tgl stays 0.
- 2 packets of 16'h0C0F, then 40000 idle cycles, then 2 packets of 16'h0C0F -> no pulse; igr_busy drops 1 cycle after timeout.
- use_igr=0 with 6 reset-combo packets -> all outputs stay 0; RST asserted mid-HOLD -> igr_busy=0 immediately, and a fresh 4-packet run is needed to fire.
- IGR_STICK_CHECK_EN defined, 4 packets of 32'h14000C0F (Y=20 > 16) -> no pulse; the same packets with Y=8 -> igr_reset fires.
